// File: rtl/fifo_uart_tx.sv
// fifo_uart_tx: pops bytes from a show-ahead sync FIFO and sends each one as a
// UART frame (start, data LSB first, optional parity, 1 or 2 stop bits) on tx.
// Optional feature macro: FIFO_UART_TX_PARITY_EN (adds a parity bit after DATA).
module fifo_uart_tx #(
  parameter int unsigned data_bus_length = 8,
  parameter int unsigned CLKS_PER_BIT    = 16,
  parameter int unsigned STOP_BITS       = 1,
  parameter int unsigned PARITY_ODD      = 0
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       fifo_empty,
  input  logic [data_bus_length-1:0] recv_data,
  output logic                       read_enable,
  output logic                       tx,
  output logic                       busy,
  output logic                       tx_done
);

  localparam int unsigned BAUD_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int unsigned BIT_W  = (data_bus_length > 1) ? $clog2(data_bus_length) : 1;

  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [BAUD_W-1:0] BAUD_PRE  = BAUD_W'(CLKS_PER_BIT - 2);
  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(data_bus_length - 1);
  localparam logic              STOP_LAST = 1'(STOP_BITS - 1);

  // Reject configurations the serialiser cannot honour.
  if (CLKS_PER_BIT < 2 || (STOP_BITS != 1 && STOP_BITS != 2) ||
      PARITY_ODD > 1 || data_bus_length < 1) begin : g_param_check
    $error("fifo_uart_tx: illegal parameter combination");
  end

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_e;

  state_e                     state_q, state_d;
  logic [BAUD_W-1:0]          baud_q, baud_d;
  logic [BIT_W-1:0]           bit_q, bit_d;
  logic                       stop_q, stop_d;
  logic [data_bus_length-1:0] shift_q, shift_d;
  logic                       tx_q, tx_d;
  logic                       busy_q, busy_d;
  logic                       done_q, done_d;
`ifdef FIFO_UART_TX_PARITY_EN
  logic                       par_q, par_d;
`endif

  logic bit_end;

  // Pop strobe: only in IDLE with data available, and never while in reset.
  assign read_enable = (state_q == S_IDLE) & ~fifo_empty & reset;
  assign bit_end     = (baud_q == BAUD_LAST);

  assign tx      = tx_q;
  assign busy    = busy_q;
  assign tx_done = done_q;

  // Next-state and registered-output logic for the frame sequencer.
  always_comb begin
    state_d = state_q;
    baud_d  = bit_end ? '0 : baud_q + 1'b1;
    bit_d   = bit_q;
    stop_d  = stop_q;
    shift_d = shift_q;
    tx_d    = tx_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
`ifdef FIFO_UART_TX_PARITY_EN
    par_d   = par_q;
`endif

    case (state_q)
      S_IDLE: begin
        baud_d = '0;
        if (read_enable) begin
          shift_d = recv_data;
          state_d = S_START;
          tx_d    = 1'b0;
          busy_d  = 1'b1;
          bit_d   = '0;
          stop_d  = 1'b0;
`ifdef FIFO_UART_TX_PARITY_EN
          par_d   = (^recv_data) ^ 1'(PARITY_ODD);
`endif
        end
      end

      S_START: begin
        if (bit_end) begin
          state_d = S_DATA;
          tx_d    = shift_q[0];
        end
      end

      S_DATA: begin
        if (bit_end) begin
          if (bit_q == BIT_LAST) begin
`ifdef FIFO_UART_TX_PARITY_EN
            state_d = S_PARITY;
            tx_d    = par_q;
`else
            state_d = S_STOP;
            tx_d    = 1'b1;
`endif
          end else begin
            bit_d   = bit_q + 1'b1;
            shift_d = shift_q >> 1;
            tx_d    = shift_d[0];
          end
        end
      end

`ifdef FIFO_UART_TX_PARITY_EN
      S_PARITY: begin
        if (bit_end) begin
          state_d = S_STOP;
          tx_d    = 1'b1;
        end
      end
`endif

      S_STOP: begin
        // Raise tx_done one cycle early so the register lands on the final cycle.
        if (stop_q == STOP_LAST && baud_q == BAUD_PRE) begin
          done_d = 1'b1;
        end
        if (bit_end) begin
          if (stop_q == STOP_LAST) begin
            state_d = S_IDLE;
            busy_d  = 1'b0;
          end else begin
            stop_d = 1'b1;
          end
        end
      end

      default: begin
        state_d = S_IDLE;
        tx_d    = 1'b1;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and output registers; reset aborts any frame and idles the line.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      stop_q  <= 1'b0;
      shift_q <= '0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef FIFO_UART_TX_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      stop_q  <= stop_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
`ifdef FIFO_UART_TX_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Testbench for fifo_uart_tx: a 16-deep show-ahead FIFO model feeds the main
// instance; a line decoder pops expected bytes from a scoreboard queue. A second
// instance with two stop bits is driven directly for exact cycle checks.
module tb_fifo_uart_tx;

  localparam int unsigned CPB = 4;
  localparam int unsigned DW  = 8;
`ifdef FIFO_UART_TX_PARITY_EN
  localparam int unsigned PBITS = 1;
`else
  localparam int unsigned PBITS = 0;
`endif
  localparam int unsigned FRAME_BITS  = 1 + DW + PBITS + 1;
  localparam int unsigned DONE_LAT    = FRAME_BITS * CPB;
  localparam int unsigned PERIOD      = DONE_LAT + 1;
  localparam int unsigned FRAME2_BITS = 1 + DW + PBITS + 2;
  localparam int unsigned DONE2_LAT   = FRAME2_BITS * CPB;

  logic       clk = 1'b0;
  logic       reset;
  logic       fifo_empty;
  logic [7:0] recv_data;
  logic       read_enable, tx, busy, tx_done;

  logic       fifo_empty2;
  logic [7:0] recv_data2;
  logic       read_enable2, tx2, busy2, tx_done2;

  int errors = 0;
  int checks = 0;
  int ncyc   = 0;
  int last_re = 0;
  int pops   = 0;
  bit mon_en = 1'b0;

  logic [7:0] exp_q[$];
  int         re_times[$];

  // FIFO model
  logic [7:0] mem [16];
  logic [3:0] wptr, rptr;
  logic [4:0] count;
  logic       wr_en;
  logic [7:0] wr_data;
  logic       wr_ok;

  always #5 clk = ~clk;

  fifo_uart_tx #(.data_bus_length(DW), .CLKS_PER_BIT(CPB), .STOP_BITS(1), .PARITY_ODD(0)) dut (
    .clk(clk), .reset(reset), .fifo_empty(fifo_empty), .recv_data(recv_data),
    .read_enable(read_enable), .tx(tx), .busy(busy), .tx_done(tx_done));

  fifo_uart_tx #(.data_bus_length(DW), .CLKS_PER_BIT(CPB), .STOP_BITS(2), .PARITY_ODD(0)) dut2 (
    .clk(clk), .reset(reset), .fifo_empty(fifo_empty2), .recv_data(recv_data2),
    .read_enable(read_enable2), .tx(tx2), .busy(busy2), .tx_done(tx_done2));

  assign fifo_empty = (count == 5'd0);
  assign recv_data  = mem[rptr];
  assign wr_ok      = wr_en && (count < 5'd16);

  always @(posedge clk) begin
    if (wr_ok) begin
      mem[wptr] <= wr_data;
      wptr      <= wptr + 4'd1;
    end
    if (read_enable) begin
      rptr <= rptr + 4'd1;
      pops <= pops + 1;
    end
    count <= 5'(count + 5'(wr_ok) - 5'(read_enable));
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h required %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic push_byte(input logic [7:0] b, input bit score);
    wr_en   = 1'b1;
    wr_data = b;
    if (score) exp_q.push_back(b);
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic wait_re(input int budget);
    bit seen = 1'b0;
    for (int k = 0; k < budget; k++) begin
      if (read_enable) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!seen) check("read_enable_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_idle(input int budget);
    bit seen = 1'b0;
    for (int k = 0; k < budget; k++) begin
      @(negedge clk);
      if (!busy && fifo_empty && tx && !wr_en) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) check("idle_timeout", 32'd0, 32'd1);
  endtask

  // Timing monitor: pop legality and tx_done latency relative to the pop.
  always @(negedge clk) begin
    ncyc++;
    if (mon_en) begin
      if (read_enable) begin
        check("pop_when_nonempty", 32'(fifo_empty), 32'd0);
        re_times.push_back(ncyc);
        last_re = ncyc;
      end
      if (tx_done) check("tx_done_latency", 32'(ncyc - last_re), 32'(DONE_LAT));
    end
  end

  // Line decoder and scoreboard: samples the second cycle of every bit.
  logic [7:0] mon_b;
  logic       mon_p;
  initial begin
    forever begin
      @(negedge clk);
      if (mon_en && tx === 1'b0) begin
        @(negedge clk);
        check("start_bit", 32'(tx), 32'd0);
        for (int i = 0; i < int'(DW); i++) begin
          repeat (CPB) @(negedge clk);
          mon_b[i] = tx;
        end
`ifdef FIFO_UART_TX_PARITY_EN
        repeat (CPB) @(negedge clk);
        mon_p = tx;
        check("parity_bit", 32'(mon_p), 32'((^mon_b) ^ 1'b0));
`else
        mon_p = 1'b0;
`endif
        repeat (CPB) @(negedge clk);
        check("stop_bit", 32'(tx), 32'd1);
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_frame: got byte %0h required none", mon_b);
        end else begin
          check("decoded_byte", 32'(mon_b), 32'(exp_q.pop_front()));
        end
      end
    end
  end

  initial begin
    #2_000_000;
    errors++;
    $display("FAIL watchdog: simulation did not complete");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1);
  end

  // Expected line levels, one entry per bit time.
`ifdef FIFO_UART_TX_PARITY_EN
  logic pat_a5 [FRAME_BITS]  = '{0, 1,0,1,0,0,1,0,1, 0, 1};
  logic pat_81 [FRAME2_BITS] = '{0, 1,0,0,0,0,0,0,1, 0, 1,1};
`else
  logic pat_a5 [FRAME_BITS]  = '{0, 1,0,1,0,0,1,0,1, 1};
  logic pat_81 [FRAME2_BITS] = '{0, 1,0,0,0,0,0,0,1, 1,1};
`endif

  initial begin
    int pops0, bad_tx, bad_re, bad_busy, n0;
    reset       = 1'b0;
    wr_en       = 1'b0;
    wr_data     = 8'h00;
    wptr        = '0;
    rptr        = '0;
    count       = '0;
    fifo_empty2 = 1'b1;
    recv_data2  = 8'h00;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_tx", 32'(tx), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_tx_done", 32'(tx_done), 32'd0);
    check("rst_read_enable", 32'(read_enable), 32'd0);
    check("rst_tx2", 32'(tx2), 32'd1);
    reset = 1'b1;
    @(negedge clk);

    // Reset in the middle of DATA for byte 0x3C
    push_byte(8'h3C, 1'b0);
    wait_re(20);
    repeat (12) @(negedge clk);
    check("pre_abort_busy", 32'(busy), 32'd1);
    #1 reset = 1'b0;
    #1;
    check("abort_tx", 32'(tx), 32'd1);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_read_enable", 32'(read_enable), 32'd0);
    check("abort_tx_done", 32'(tx_done), 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    bad_tx = 0; bad_re = 0; bad_busy = 0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (tx !== 1'b1) bad_tx++;
      if (read_enable !== 1'b0) bad_re++;
      if (busy !== 1'b0) bad_busy++;
    end
    check("post_reset_tx_not_idle_cycles", 32'(bad_tx), 32'd0);
    check("post_reset_pop_cycles", 32'(bad_re), 32'd0);
    check("post_reset_busy_cycles", 32'(bad_busy), 32'd0);

    // Single byte 0xA5 with exact line pattern
    mon_en = 1'b1;
    pops0 = pops;
    push_byte(8'hA5, 1'b1);
    wait_re(20);
    repeat (2) @(negedge clk);
    for (int b = 0; b < int'(FRAME_BITS); b++) begin
      if (b > 0) repeat (CPB) @(negedge clk);
      check($sformatf("a5_bit%0d", b), 32'(tx), 32'(pat_a5[b]));
    end
    wait_idle(200);
    check("a5_pop_count", 32'(pops - pops0), 32'd1);

    // Back-to-back 0x00, 0xFF, 0x55
    pops0 = pops;
    re_times.delete();
    push_byte(8'h00, 1'b1);
    push_byte(8'hFF, 1'b1);
    push_byte(8'h55, 1'b1);
    wait_idle(600);
    repeat (20) @(negedge clk);
    check("b2b_pop_count", 32'(pops - pops0), 32'd3);
    check("b2b_pulse_count", 32'(re_times.size()), 32'd3);
    if (re_times.size() == 3) begin
      check("b2b_gap0", 32'(re_times[1] - re_times[0]), 32'(PERIOD));
      check("b2b_gap1", 32'(re_times[2] - re_times[1]), 32'(PERIOD));
    end

    // Parity-sensitive bytes (odd and even popcount)
    pops0 = pops;
    push_byte(8'h07, 1'b1);
    push_byte(8'hA5, 1'b1);
    wait_idle(600);
    check("parity_pair_pop_count", 32'(pops - pops0), 32'd2);

    // Two stop bits, byte 0x81, on the second instance
    @(negedge clk);
    fifo_empty2 = 1'b0;
    recv_data2  = 8'h81;
    #1;
    check("stop2_read_enable", 32'(read_enable2), 32'd1);
    @(negedge clk);
    fifo_empty2 = 1'b1;
    for (int k = 1; k <= int'(DONE2_LAT) + 1; k++) begin
      if (k > 1) @(negedge clk);
      if (k <= int'(DONE2_LAT))
        check($sformatf("stop2_tx_c%0d", k), 32'(tx2), 32'(pat_81[(k - 1) / int'(CPB)]));
      check($sformatf("stop2_done_c%0d", k), 32'(tx_done2), 32'(k == int'(DONE2_LAT)));
      check($sformatf("stop2_busy_c%0d", k), 32'(busy2), 32'(k <= int'(DONE2_LAT)));
    end
    check("stop2_tx_idle", 32'(tx2), 32'd1);
    check("stop2_no_repop", 32'(read_enable2), 32'd0);

    // Fill FIFO to full while a frame is in flight, then drain
    pops0 = pops;
    push_byte(8'h11, 1'b1);
    wait_re(20);
    repeat (2) @(negedge clk);
    for (int i = 0; i < 16; i++) push_byte(8'((i * 37 + 5) & 8'hFF), 1'b1);
    n0 = 32'(count);
    check("fill_reaches_full", 32'(n0), 32'd16);
    wait_idle(17 * PERIOD + 200);
    repeat (5) @(negedge clk);
    check("drain_pop_count", 32'(pops - pops0), 32'd17);
    check("drain_scoreboard_empty", 32'(exp_q.size()), 32'd0);
    check("drain_fifo_empty", 32'(fifo_empty), 32'd1);
    check("drain_tx_idle", 32'(tx), 32'd1);
    check("drain_busy", 32'(busy), 32'd0);

    repeat (10) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
